stage3_pool_flatten: RTL and testbench
======================================

# stage3_pool_flatten

Receiving end of the stage-3 max-pooling output stream. It collects one frame of pooled pixels (all channels), arriving as single-cycle `valid` beats, into an internal register array. Once the frame is complete, it replays the frame as a flattened, one-element-per-beat stream with a valid/ready handshake toward the fully-connected stage. It sits between stage-3 pooling and the FC input, and turns the parallel per-channel pool beats into the serial vector the FC layer consumes.

## Interface
Parameters:
- `CH`, 3, channels per pool beat; equals the pooling channel count.
- `DW`, 32, bits per pooled value; signed two's complement, passed through unchanged.
- `N_POS`, 16, pooled positions per frame (4x4 pooled map).
- `IDX_W`, 6, width of `o_index`; must satisfy 2^`IDX_W` ≥ `CH`*`N_POS`.

Ports:
- `clk`  in  1  clock, all logic on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `i_pool_valid`  in  1  one pooled beat present this cycle; there is no backpressure on this side.
- `i_pool_data`  in  `CH`*`DW`  channel c occupies bits [c*`DW` +: `DW`].
- `o_valid`  out  1  flattened element valid.
- `o_data`  out  `DW`  flattened element.
- `o_index`  out  `IDX_W`  flat index of the current element, 0..`CH`*`N_POS`-1.
- `o_last`  out  1  high together with the final element of the frame.
- `i_ready`  in  1  FC stage accepts the element.
- `o_busy`  out  1  high while not in COLLECT; input beats are not accepted.
- `o_drop_err`  out  1  sticky; set when a beat arrives while `o_busy` is high.

## Operation
- Storage: `mem[pos][ch]` is a `DW`-bit register array; no RAM macro.
- State register has three states:
  - COLLECT (reset state): each `i_pool_valid` writes all `CH` lanes to `mem[wr_pos]`, then `wr_pos` increments. A write with `wr_pos`==`N_POS`-1 sets `wr_pos` to 0 and moves the state to LOAD.
  - LOAD: loads `o_data`/`o_index` for flat index 0, sets `o_valid`=1, and moves to DRAIN.
  - DRAIN: a transfer occurs when `o_valid`&&`i_ready`.
    - On a transfer of flat index k < `CH`*`N_POS`-1, load element k+1 the same edge; `o_valid` stays 1.
    - On the transfer of the last element, `o_valid`, `o_last` and `o_index` go to 0 and the state moves to COLLECT.
- Flat order (default, channel-major): flat index k maps to ch = k / `N_POS`, pos = k % `N_POS`.
- Stall: while `o_valid` && !`i_ready`, `o_data`, `o_index` and `o_last` hold stable.
- `o_last` = (`o_index` == `CH`*`N_POS`-1) && `o_valid`; it is registered with the data.
- Drops: `i_pool_valid` in LOAD or DRAIN discards the beat, leaves `mem` and `wr_pos` untouched, and sets `o_drop_err`. `o_drop_err` clears only on reset.
- Reset mid-frame (assert `reset_n`): the partially collected frame is discarded, `wr_pos`=0, state is COLLECT. `mem` contents are don't-care.

## Timing
- Reset values: `o_valid`=0, `o_data`=0, `o_index`=0, `o_last`=0, `o_busy`=0, `o_drop_err`=0.
- Final pool beat accepted in cycle t:
  - `o_busy`=1 from cycle t+1.
  - `o_valid`=1 with index 0 from cycle t+2.
- With `i_ready` held high, elements 0..`CH`*`N_POS`-1 appear in cycles t+2..t+1+`CH`*`N_POS`, one per cycle. Defaults give t+2..t+49.
- The last handshake is at cycle d. In cycle d+1, `o_valid`=0 and `o_busy`=0, and an `i_pool_valid` in cycle d+1 is accepted as pos 0.
- A beat arriving in cycle d itself is dropped and flagged.
- `i_ready` may toggle arbitrarily. Exactly one element transfers per cycle in which `o_valid`&&`i_ready`.
- `o_busy` is a registered decode of the state, so it carries no combinational path from the inputs.

## Configuration
- `STAGE3_FLATTEN_POS_MAJOR_EN`:
  - Defined: flat order is position-major, flat index k maps to pos = k / `CH`, ch = k % `CH`. This matches the FC weight layout when it interleaves channels.
  - Undefined: channel-major order as in Operation.
- Timing, the handshake and `o_index` semantics are identical in both builds.

## Test plan
- Ramp frame: 16 beats with lane c = 100*c + pos, `i_ready`=1 → 48 outputs in consecutive cycles.
  - Default build: `o_data` = 0,1,..,15,100,..,115,200,..,215.
  - `STAGE3_FLATTEN_POS_MAJOR_EN` build: 0,100,200,1,101,201,…
  - `o_last` high only at index 47.
- Backpressure: same frame, `i_ready` = 1,0,0,1 repeating → each element is held until accepted, there are no duplicates or skips, and drain completes 48 handshakes later.
- Negative data: lane values 0xFFFFFFF0 and 0x80000000 → output bit-exact, with no sign manipulation.
- Drop: inject `i_pool_valid` at LOAD and at mid-DRAIN → `o_drop_err`=1 stays set, and the drained frame and the next frame are both uncorrupted.
- Reset mid-frame: 7 beats, pulse `reset_n` low, then a full 16-beat frame → outputs reflect only the new frame, with `o_drop_err`=0.
- Back-to-back: start a second frame in the cycle after the last handshake → accepted with no drop, and `o_valid` rises 2 cycles after its 16th beat.

Source files
------------

// File: rtl/stage3_pool_flatten.sv
// ---------------------------------------------------------------------------
// stage3_pool_flatten
//
// Purpose:
//   Receiving end of the stage-3 max-pooling output stream. One frame of
//   pooled pixels (N_POS positions x CH channels) arrives as single-cycle
//   beats carrying all channels of one position. The beats are stored in a
//   register array. When the frame is complete, it is replayed as a flattened
//   stream with one element per beat and a valid/ready handshake toward the
//   fully-connected stage.
//
// Parameters:
//   CH     channels per pool beat
//   DW     bits per pooled value (signed, passed through untouched)
//   N_POS  pooled positions per frame
//   IDX_W  width of o_index, 2**IDX_W >= CH*N_POS
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous, active-low reset
//   i_pool_valid  one pooled beat present this cycle (no backpressure)
//   i_pool_data   channel c occupies bits [c*DW +: DW]
//   o_valid       flattened element valid
//   o_data        flattened element
//   o_index       flat index of the current element
//   o_last        high together with the final element of the frame
//   i_ready       FC stage accepts the element
//   o_busy        high while not collecting; input beats are discarded
//   o_drop_err    sticky flag, set when a beat arrives while busy
//
// Build option:
//   STAGE3_FLATTEN_POS_MAJOR_EN  defined   -> position-major flat order
//                                          (k -> pos = k / CH, ch = k % CH)
//                                undefined -> channel-major flat order
//                                          (k -> ch = k / N_POS, pos = k % N_POS)
// ---------------------------------------------------------------------------
module stage3_pool_flatten #(
    parameter int CH    = 3,
    parameter int DW    = 32,
    parameter int N_POS = 16,
    parameter int IDX_W = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_pool_valid,
    input  logic [CH*DW-1:0]   i_pool_data,
    output logic               o_valid,
    output logic [DW-1:0]      o_data,
    output logic [IDX_W-1:0]   o_index,
    output logic               o_last,
    input  logic               i_ready,
    output logic               o_busy,
    output logic               o_drop_err
);

    localparam int TOTAL = CH * N_POS;
    localparam int POS_W = (N_POS > 1) ? $clog2(N_POS) : 1;
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_POS - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [CH_W-1:0]  CH_ONE   = CH_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [POS_W-1:0] POS_ZERO = '0;
    localparam logic [CH_W-1:0]  CH_ZERO  = '0;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [POS_W-1:0] wr_pos_q, wr_pos_d;
    logic [POS_W-1:0] rd_pos_q, rd_pos_d;
    logic [CH_W-1:0]  rd_ch_q, rd_ch_d;
    logic             valid_q, valid_d;
    logic [DW-1:0]    data_q, data_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             drop_q, drop_d;

    logic [DW-1:0]    mem_q [N_POS][CH];

    logic             wr_en;
    logic             xfer;
    logic [POS_W-1:0] nxt_pos;
    logic [CH_W-1:0]  nxt_ch;
    logic [IDX_W-1:0] nxt_idx;

    // The read side walks a (pos, ch) pointer pair instead of dividing the
    // flat index, so no divider is needed. This block produces the pointer
    // of the element that follows the one currently presented.
    always_comb begin
        nxt_pos = rd_pos_q;
        nxt_ch  = rd_ch_q;
`ifdef STAGE3_FLATTEN_POS_MAJOR_EN
        if (rd_ch_q == CH_LAST) begin
            nxt_ch  = CH_ZERO;
            nxt_pos = rd_pos_q + POS_ONE;
        end else begin
            nxt_ch  = rd_ch_q + CH_ONE;
        end
`else
        if (rd_pos_q == POS_LAST) begin
            nxt_pos = POS_ZERO;
            nxt_ch  = rd_ch_q + CH_ONE;
        end else begin
            nxt_pos = rd_pos_q + POS_ONE;
        end
`endif
    end

    assign nxt_idx = index_q + IDX_ONE;
    assign xfer    = valid_q && i_ready;

    // Next-state logic for the collect / load / drain sequence. Everything
    // holds by default, so a stalled element stays stable without extra
    // terms. Beats that arrive outside COLLECT are discarded and flagged.
    always_comb begin
        state_d  = state_q;
        wr_pos_d = wr_pos_q;
        rd_pos_d = rd_pos_q;
        rd_ch_d  = rd_ch_q;
        valid_d  = valid_q;
        data_d   = data_q;
        index_d  = index_q;
        last_d   = last_q;
        drop_d   = drop_q;
        wr_en    = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                if (i_pool_valid) begin
                    wr_en = 1'b1;
                    if (wr_pos_q == POS_LAST) begin
                        wr_pos_d = POS_ZERO;
                        state_d  = ST_LOAD;
                    end else begin
                        wr_pos_d = wr_pos_q + POS_ONE;
                    end
                end
            end

            ST_LOAD: begin
                rd_pos_d = POS_ZERO;
                rd_ch_d  = CH_ZERO;
                valid_d  = 1'b1;
                data_d   = mem_q[POS_ZERO][CH_ZERO];
                index_d  = '0;
                last_d   = (IDX_LAST == '0);
                state_d  = ST_DRAIN;
            end

            ST_DRAIN: begin
                if (xfer) begin
                    if (index_q == IDX_LAST) begin
                        valid_d = 1'b0;
                        data_d  = '0;
                        index_d = '0;
                        last_d  = 1'b0;
                        state_d = ST_COLLECT;
                    end else begin
                        rd_pos_d = nxt_pos;
                        rd_ch_d  = nxt_ch;
                        valid_d  = 1'b1;
                        data_d   = mem_q[nxt_pos][nxt_ch];
                        index_d  = nxt_idx;
                        last_d   = (nxt_idx == IDX_LAST);
                    end
                end
            end

            default: begin
                state_d = ST_COLLECT;
            end
        endcase

        if (i_pool_valid && (state_q != ST_COLLECT)) begin
            drop_d = 1'b1;
        end

        // Busy is registered from the next state so that it lines up with
        // the state register and has no combinational path from inputs.
        busy_d = (state_d != ST_COLLECT);
    end

    // Control and output registers, cleared by the asynchronous reset. A
    // reset mid-frame discards the partial frame by clearing wr_pos.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_COLLECT;
            wr_pos_q <= POS_ZERO;
            rd_pos_q <= POS_ZERO;
            rd_ch_q  <= CH_ZERO;
            valid_q  <= 1'b0;
            data_q   <= '0;
            index_q  <= '0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_pos_q <= wr_pos_d;
            rd_pos_q <= rd_pos_d;
            rd_ch_q  <= rd_ch_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            index_q  <= index_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            drop_q   <= drop_d;
        end
    end

    // Frame storage has no reset: its contents only matter once a full frame
    // has been written, and every location is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < CH; c++) begin
                mem_q[wr_pos_q][c] <= i_pool_data[c*DW +: DW];
            end
        end
    end

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_index    = index_q;
    assign o_last     = last_q;
    assign o_busy     = busy_q;
    assign o_drop_err = drop_q;

endmodule

// File: tb/tb_stage3_pool_flatten.sv
// Directed testbench for stage3_pool_flatten: ramp frame at full rate,
// backpressure, back-to-back frames, negative data, dropped beats and a
// reset in the middle of a frame. Builds with or without
// STAGE3_FLATTEN_POS_MAJOR_EN; the expected flat order follows the macro.
module tb_stage3_pool_flatten;

    localparam int CH    = 3;
    localparam int DW    = 32;
    localparam int N_POS = 16;
    localparam int IDX_W = 6;
    localparam int TOTAL = CH * N_POS;

    logic               clk;
    logic               reset_n;
    logic               i_pool_valid;
    logic [CH*DW-1:0]   i_pool_data;
    logic               o_valid;
    logic [DW-1:0]      o_data;
    logic [IDX_W-1:0]   o_index;
    logic               o_last;
    logic               i_ready;
    logic               o_busy;
    logic               o_drop_err;

    int checks   = 0;
    int failures = 0;
    int cycUsed;

    logic [DW-1:0] tbFrame [N_POS][CH];

    stage3_pool_flatten #(
        .CH    (CH),
        .DW    (DW),
        .N_POS (N_POS),
        .IDX_W (IDX_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_pool_valid (i_pool_valid),
        .i_pool_data  (i_pool_data),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_index      (o_index),
        .o_last       (o_last),
        .i_ready      (i_ready),
        .o_busy       (o_busy),
        .o_drop_err   (o_drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Frame contents: 0 = ramp (100*c + pos), 1 = negative values,
    // 2 = junk for the aborted frame.
    task automatic fillFrame(input int kind);
        for (int p = 0; p < N_POS; p++) begin
            for (int c = 0; c < CH; c++) begin
                case (kind)
                    0: tbFrame[p][c] = 32'(100 * c + p);
                    1: begin
                        if (c == 0)      tbFrame[p][c] = 32'hFFFFFFF0 + 32'(p);
                        else if (c == 1) tbFrame[p][c] = 32'h80000000 + 32'(p);
                        else             tbFrame[p][c] = 32'hFFFFFFF0 ^ (32'(p) << 8);
                    end
                    default: tbFrame[p][c] = 32'(9000 + 10 * c + p);
                endcase
            end
        end
    endtask

    function automatic logic [DW-1:0] expElem(input int k);
        int ch;
        int pos;
`ifdef STAGE3_FLATTEN_POS_MAJOR_EN
        pos = k / CH;
        ch  = k % CH;
`else
        ch  = k / N_POS;
        pos = k % N_POS;
`endif
        return tbFrame[pos][ch];
    endfunction

    // Drive one pool beat for position pos from tbFrame.
    task automatic applyStimulus(input int pos);
        i_pool_valid = 1'b1;
        for (int c = 0; c < CH; c++) begin
            i_pool_data[c*DW +: DW] = tbFrame[pos][c];
        end
        tick();
        i_pool_valid = 1'b0;
    endtask

    task automatic driveJunkBeat();
        i_pool_valid = 1'b1;
        for (int c = 0; c < CH; c++) begin
            i_pool_data[c*DW +: DW] = 32'hDEADBEEF;
        end
    endtask

    // Send a full frame and check the busy / valid timing around it.
    // Returns at the cycle where element 0 is first presented.
    task automatic sendFrame(input bit injectLoad);
        for (int p = 0; p < N_POS; p++) begin
            if (p == N_POS - 1) checkOutput("busy_before_last_beat", {31'b0, o_busy}, 32'd0);
            applyStimulus(p);
        end
        checkOutput("busy_after_last_beat", {31'b0, o_busy}, 32'd1);
        checkOutput("valid_low_in_load", {31'b0, o_valid}, 32'd0);
        if (injectLoad) driveJunkBeat();
        tick();
        i_pool_valid = 1'b0;
        checkOutput("valid_rise", {31'b0, o_valid}, 32'd1);
        checkOutput("first_index", 32'(o_index), 32'd0);
    endtask

    // Drain a frame. mode 0: ready always high; mode 1: ready 1,0,0,1 ...
    // dropAt >= 0 injects a beat in the cycle element dropAt is presented.
    task automatic drainFrame(input int mode, input int dropAt, output int cycles);
        int  k;
        int  cyc;
        bit  prevStall;
        bit  dropped;
        logic [DW-1:0]    heldData;
        logic [IDX_W-1:0] heldIdx;
        logic             heldLast;
        k = 0; cyc = 0; prevStall = 1'b0; dropped = 1'b0;
        heldData = '0; heldIdx = '0; heldLast = 1'b0;
        while (k < TOTAL && cyc < 400) begin
            i_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (k == dropAt && !dropped) begin
                driveJunkBeat();
                dropped = 1'b1;
            end
            if (prevStall) begin
                checkOutput("stall_data", o_data, heldData);
                checkOutput("stall_index", 32'(o_index), 32'(heldIdx));
                checkOutput("stall_last", {31'b0, o_last}, {31'b0, heldLast});
            end
            if (o_valid && i_ready) begin
                checkOutput("elem_data", o_data, expElem(k));
                checkOutput("elem_index", 32'(o_index), 32'(k));
                checkOutput("elem_last", {31'b0, o_last}, {31'b0, (k == TOTAL - 1)});
                k++;
                prevStall = 1'b0;
            end else begin
                checkOutput("valid_held_in_stall", {31'b0, o_valid}, 32'd1);
                prevStall = 1'b1;
                heldData  = o_data;
                heldIdx   = o_index;
                heldLast  = o_last;
            end
            tick();
            i_pool_valid = 1'b0;
            cyc++;
        end
        i_ready = 1'b0;
        checkOutput("drain_handshakes", 32'(k), 32'(TOTAL));
        checkOutput("valid_after_drain", {31'b0, o_valid}, 32'd0);
        checkOutput("busy_after_drain", {31'b0, o_busy}, 32'd0);
        checkOutput("last_after_drain", {31'b0, o_last}, 32'd0);
        checkOutput("index_after_drain", 32'(o_index), 32'd0);
        cycles = cyc;
    endtask

    initial begin
        reset_n      = 1'b0;
        i_pool_valid = 1'b0;
        i_pool_data  = '0;
        i_ready      = 1'b0;
        tick();
        tick();

        // Reset values
        checkOutput("reset_valid", {31'b0, o_valid}, 32'd0);
        checkOutput("reset_data", o_data, 32'd0);
        checkOutput("reset_index", 32'(o_index), 32'd0);
        checkOutput("reset_last", {31'b0, o_last}, 32'd0);
        checkOutput("reset_busy", {31'b0, o_busy}, 32'd0);
        checkOutput("reset_drop", {31'b0, o_drop_err}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Ramp frame at full rate
        $display("[TB] ramp frame, ready held high");
        fillFrame(0);
        sendFrame(1'b0);
        checkOutput("ramp_elem0_const", o_data, 32'd0);
        drainFrame(0, -1, cycUsed);
        checkOutput("full_rate_cycles", 32'(cycUsed), 32'(TOTAL));

        // Backpressure, started back-to-back after the previous drain
        $display("[TB] ramp frame with backpressure, back-to-back");
        sendFrame(1'b0);
        drainFrame(1, -1, cycUsed);
        checkOutput("bp_drop_clear", {31'b0, o_drop_err}, 32'd0);

        // Negative data, back-to-back again
        $display("[TB] negative data frame");
        fillFrame(1);
        sendFrame(1'b0);
        checkOutput("neg_elem0_const", o_data, 32'hFFFFFFF0);
        drainFrame(0, -1, cycUsed);
        checkOutput("neg_drop_clear", {31'b0, o_drop_err}, 32'd0);

        // Drops at LOAD and mid-DRAIN
        $display("[TB] dropped beats during load and drain");
        fillFrame(0);
        sendFrame(1'b1);
        checkOutput("drop_set_at_load", {31'b0, o_drop_err}, 32'd1);
        drainFrame(0, 20, cycUsed);
        checkOutput("drop_sticky_after_drain", {31'b0, o_drop_err}, 32'd1);
        fillFrame(1);
        sendFrame(1'b0);
        drainFrame(0, -1, cycUsed);
        checkOutput("drop_sticky_next_frame", {31'b0, o_drop_err}, 32'd1);

        // Reset in the middle of a frame
        $display("[TB] reset after 7 beats");
        fillFrame(2);
        for (int p = 0; p < 7; p++) applyStimulus(p);
        reset_n = 1'b0;
        #2;
        checkOutput("midreset_drop", {31'b0, o_drop_err}, 32'd0);
        checkOutput("midreset_busy", {31'b0, o_busy}, 32'd0);
        reset_n = 1'b1;
        tick();
        fillFrame(0);
        sendFrame(1'b0);
        drainFrame(0, -1, cycUsed);
        checkOutput("post_reset_drop", {31'b0, o_drop_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
